// File: rtl/tpu_sequencer.sv
// Programmable TPU instruction sequencer: writable instruction memory, fetch/decode of
// 16-bit instructions, control strobes for weight memory, input setup, MMU and unified buffer.
module tpu_sequencer #(
  parameter  int IMEM_DEPTH     = 8,
  parameter  int ADDR_W         = 13,
  parameter  int COMPUTE_CYCLES = 6,
  localparam int PC_W           = $clog2(IMEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_we_i,
  input  logic [PC_W-1:0]   prog_addr_i,
  input  logic [15:0]       prog_data_i,
  input  logic              start_i,
  input  logic              store_ready_i,
  output logic [ADDR_W-1:0] base_address_o,
  output logic              load_weight_o,
  output logic              load_input_o,
  output logic              valid_o,
  output logic              store_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [PC_W-1:0]   pc_o
);

  localparam int CNT_W = (COMPUTE_CYCLES > 2) ? $clog2(COMPUTE_CYCLES - 1) : 1;
  localparam int CNT_INIT = (COMPUTE_CYCLES > 1) ? (COMPUTE_CYCLES - 2) : 0;

  localparam logic [2:0] OP_HALT    = 3'd0;
  localparam logic [2:0] OP_LADDR   = 3'd1;
  localparam logic [2:0] OP_LWEIGHT = 3'd2;
  localparam logic [2:0] OP_LINPUT  = 3'd3;
  localparam logic [2:0] OP_COMPUTE = 3'd4;
  localparam logic [2:0] OP_STORE   = 3'd5;
  localparam logic [2:0] OP_LOOP    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_COMP, S_STWAIT, S_DONE
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ir_q;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        lc_q;
  logic              la_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [15:0]       imem [IMEM_DEPTH];

  logic [2:0]        op_s;
  logic              last_s;
  logic              tgt_bad_s;
  logic              loop_take_s;
  logic [PC_W-1:0]   adv_pc_d;
  state_e            adv_state_d;

  // Shared "advance" targets; running off the last word ends the program with an error, no wrap.
  always_comb begin
    op_s        = ir_q[15:13];
    last_s      = (pc_q == PC_W'(IMEM_DEPTH - 1));
    adv_pc_d    = last_s ? pc_q : (pc_q + PC_W'(1));
    adv_state_d = last_s ? S_DONE : S_FETCH;
    tgt_bad_s   = ({1'b0, ir_q[7:0]} >= 9'(IMEM_DEPTH));
    loop_take_s = la_q ? (lc_q != 5'd0) : (ir_q[12:8] != 5'd0);
  end

  // Instruction memory is writable from the host only while idle; contents survive reset.
  always_ff @(posedge clk_i) begin
    if ((state_q == S_IDLE) && prog_we_i && (int'(prog_addr_i) < IMEM_DEPTH)) begin
      imem[prog_addr_i] <= prog_data_i;
    end
  end

  // Fetch/execute state machine with program counter, loop registers and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 16'd0;
      base_q  <= '0;
      lc_q    <= 5'd0;
      la_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            err_q   <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FETCH: begin
          ir_q    <= imem[pc_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (op_s)
            OP_HALT: state_q <= S_DONE;
            OP_LADDR: begin
              base_q  <= ir_q[ADDR_W-1:0];
              state_q <= adv_state_d;
              pc_q    <= adv_pc_d;
              err_q   <= err_q | last_s;
            end
            OP_COMPUTE: begin
              if (COMPUTE_CYCLES == 1) begin
                state_q <= adv_state_d;
                pc_q    <= adv_pc_d;
                err_q   <= err_q | last_s;
              end else begin
                cnt_q   <= CNT_W'(CNT_INIT);
                state_q <= S_COMP;
              end
            end
            OP_STORE: begin
              if (store_ready_i) begin
                state_q <= adv_state_d;
                pc_q    <= adv_pc_d;
                err_q   <= err_q | last_s;
              end else begin
                state_q <= S_STWAIT;
              end
            end
            OP_LOOP: begin
              if (tgt_bad_s) begin
                err_q   <= 1'b1;
                state_q <= S_DONE;
              end else if (loop_take_s) begin
                // One loop level only: a LOOP seen inside a body shares the same counter.
                la_q    <= 1'b1;
                lc_q    <= la_q ? (lc_q - 5'd1) : (ir_q[12:8] - 5'd1);
                pc_q    <= ir_q[PC_W-1:0];
                state_q <= S_FETCH;
              end else begin
                la_q    <= 1'b0;
                state_q <= adv_state_d;
                pc_q    <= adv_pc_d;
                err_q   <= err_q | last_s;
              end
            end
            default: begin
              state_q <= adv_state_d;
              pc_q    <= adv_pc_d;
              err_q   <= err_q | last_s;
            end
          endcase
        end
        S_COMP: begin
          if (cnt_q == '0) begin
            state_q <= adv_state_d;
            pc_q    <= adv_pc_d;
            err_q   <= err_q | last_s;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_STWAIT: begin
          if (store_ready_i) begin
            state_q <= adv_state_d;
            pc_q    <= adv_pc_d;
            err_q   <= err_q | last_s;
          end else begin
            state_q <= S_STWAIT;
          end
        end
        S_DONE: begin
          la_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode only registered state and IR, so they fall with the asynchronous reset.
  assign load_weight_o  = (state_q == S_EXEC) && (op_s == OP_LWEIGHT);
  assign load_input_o   = (state_q == S_EXEC) && (op_s == OP_LINPUT);
  assign valid_o        = ((state_q == S_EXEC) && (op_s == OP_COMPUTE)) || (state_q == S_COMP);
  assign store_o        = ((state_q == S_EXEC) && (op_s == OP_STORE)) || (state_q == S_STWAIT);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign error_o        = err_q;
  assign pc_o           = pc_q;
  assign base_address_o = base_q;

endmodule
